// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM states, {lt,eq,gt} result encoding and sizing helper
// for the bit-serial comparator.
package cmp_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [2:0] LT = 3'b100;
   localparam logic [2:0] EQ = 3'b010;
   localparam logic [2:0] GT = 3'b001;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/cmp_bit_cell.sv
// cmp_bit_cell: one-bit cascade magnitude-compare cell; l/g stay sticky once the
// operands have diverged.
module cmp_bit_cell (
   input  logic a,
   input  logic b,
   input  logic l,
   input  logic g,
   input  logic e,
   output logic lt,
   output logic gt,
   output logic eq
);
   assign lt = l | (e & ~a & b);
   assign gt = g | (e & a & ~b);
   assign eq = e & ~(a ^ b);
endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: bit-serial MSB-first magnitude comparator reusing a single
// cascade cell, with start/busy/done handshake and optional early exit.
module serial_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit EARLY_EXIT = 1'b1,
   localparam int CW = clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [CW-1:0]    steps
);
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic l_q, l_d, g_q, g_d, e_q, e_d;
   logic [CW-1:0] idx_q, idx_d, cnt_q, cnt_d, steps_q, steps_d;
   logic [2:0] res_q, res_d;
   logic l_n, g_n, e_n;

   cmp_bit_cell u_cell (
      .a  (a_sh_q[WIDTH-1]),
      .b  (b_sh_q[WIDTH-1]),
      .l  (l_q),
      .g  (g_q),
      .e  (e_q),
      .lt (l_n),
      .gt (g_n),
      .eq (e_n)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      l_d     = l_q;
      g_d     = g_q;
      e_d     = e_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      steps_d = steps_q;
      res_d   = res_q;
      if (state_q == RUN) begin
         a_sh_d = a_sh_q << 1;
         b_sh_d = b_sh_q << 1;
         l_d    = l_n;
         g_d    = g_n;
         e_d    = e_n;
         cnt_d  = cnt_q + CW'(1);
         idx_d  = idx_q - CW'(1);
         // results are captured on the way into DONE so they are valid with done
         if (idx_q == '0 || (EARLY_EXIT && !e_n)) begin
            state_d = DONE;
            res_d   = l_n ? LT : (g_n ? GT : EQ);
            steps_d = cnt_q + CW'(1);
         end
      end else if (start) begin
         state_d = RUN;
         a_sh_d  = a;
         b_sh_d  = b;
         l_d     = 1'b0;
         g_d     = 1'b0;
         e_d     = 1'b1;
         idx_d   = CW'(WIDTH - 1);
         cnt_d   = '0;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         l_q     <= 1'b0;
         g_q     <= 1'b0;
         e_q     <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         steps_q <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         l_q     <= l_d;
         g_q     <= g_d;
         e_q     <= e_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         steps_q <= steps_d;
         res_q   <= res_d;
      end
   end

   assign busy         = (state_q == RUN);
   assign done         = (state_q == DONE);
   assign {lt, eq, gt} = res_q;
   assign steps        = steps_q;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb_serial_cmp_ctrl: drives an EARLY_EXIT=1 and an EARLY_EXIT=0 instance with
// shared stimulus and checks both against a cycle-count behavioural model.
module tb_serial_cmp_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [7:0] a, b;
   logic [1:0] busy, done, lt, eq, gt;
   logic [3:0] steps [2];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy[0]), .done(done[0]), .lt(lt[0]), .eq(eq[0]), .gt(gt[0]), .steps(steps[0])
   );
   serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ee0 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy[1]), .done(done[1]), .lt(lt[1]), .eq(eq[1]), .gt(gt[1]), .steps(steps[1])
   );

   function automatic int n_for(input logic [7:0] x, input logic [7:0] y, input bit ee);
      logic [7:0] d;
      d = x ^ y;
      if (!ee || d == 8'd0) return 8;
      for (int i = 7; i >= 0; i--) if (d[i]) return 8 - i;
      return 8;
   endfunction

   function automatic logic [2:0] res_for(input logic [7:0] x, input logic [7:0] y);
      return (x < y) ? 3'b100 : (x == y) ? 3'b010 : 3'b001;
   endfunction

   // model: remaining busy cycles per instance; result appears when it runs out
   int         bl [2];
   logic       md [2];
   logic [2:0] mres [2], pres [2];
   int         msteps [2], pn [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            bl[k]     <= 0;
            md[k]     <= 1'b0;
            mres[k]   <= 3'b000;
            msteps[k] <= 0;
         end else if (bl[k] != 0) begin
            bl[k] <= bl[k] - 1;
            md[k] <= (bl[k] == 1);
            if (bl[k] == 1) begin
               mres[k]   <= pres[k];
               msteps[k] <= pn[k];
            end
         end else begin
            md[k] <= 1'b0;
            if (start) begin
               bl[k]   <= n_for(a, b, k == 0);
               pres[k] <= res_for(a, b);
               pn[k]   <= n_for(a, b, k == 0);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         chk($sformatf("cycle_u%0d", k),
             int'({busy[k], done[k], lt[k], eq[k], gt[k], steps[k]}),
             int'({bl[k] != 0, md[k], mres[k], 4'(msteps[k])}));
   endtask

   task automatic go(input logic [7:0] av, input logic [7:0] bv);
      a = av;
      b = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int k, input int lim, output int j);
      j = 0;
      while (!done[k] && j < lim) begin
         tick();
         j++;
      end
   endtask

   task automatic dir(input string nm, input logic [7:0] av, input logic [7:0] bv,
                      input logic [2:0] er, input int n1, input int n0);
      int j1, j2;
      go(av, bv);
      wait_done(0, 20, j1);
      chk({nm, "_lat_ee1"}, j1, n1);
      chk({nm, "_res_ee1"}, int'({lt[0], eq[0], gt[0]}), int'(er));
      chk({nm, "_steps_ee1"}, int'(steps[0]), n1);
      wait_done(1, 20, j2);
      chk({nm, "_lat_ee0"}, j1 + j2, n0);
      chk({nm, "_res_ee0"}, int'({lt[1], eq[1], gt[1]}), int'(er));
      chk({nm, "_steps_ee0"}, int'(steps[1]), n0);
      tick();
   endtask

   initial begin
      int j, sel, nd;
      rst_n = 1'b1;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("reset_u%0d", k), int'({busy[k], done[k], lt[k], eq[k], gt[k], steps[k]}), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      dir("eq_5a",   8'h5A, 8'h5A, 3'b010, 8, 8);
      dir("gt_80",   8'h80, 8'h7F, 3'b001, 1, 8);
      dir("lt_12",   8'h12, 8'h13, 3'b100, 8, 8);
      dir("lt_00ff", 8'h00, 8'hFF, 3'b100, 1, 8);
      dir("gt_fffe", 8'hFF, 8'hFE, 3'b001, 8, 8);
      dir("eq_00",   8'h00, 8'h00, 3'b010, 8, 8);
      // second start while busy must be dropped; start in the done cycle is taken
      go(8'h40, 8'h20);
      a = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(0, 20, j);
      chk("b2b_first_lat", j + 1, 2);
      chk("b2b_first_res", int'({lt[0], eq[0], gt[0]}), 3'b001);
      chk("b2b_first_steps", int'(steps[0]), 2);
      go(8'h01, 8'h02);
      wait_done(0, 20, j);
      chk("b2b_second_lat", j, 7);
      chk("b2b_second_res", int'({lt[0], eq[0], gt[0]}), 3'b100);
      chk("b2b_second_steps", int'(steps[0]), 7);
      repeat (12) tick();
      chk("b2b_ee0_res", int'({lt[1], eq[1], gt[1]}), 3'b001);
      chk("b2b_ee0_steps", int'(steps[1]), 8);
      go(8'h5A, 8'h5A);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("midrun_reset_u%0d", k), int'({busy[k], done[k], lt[k], eq[k], gt[k], steps[k]}), 0);
      tick();
      rst_n = 1'b1;
      tick();
      dir("post_rst", 8'hA5, 8'hA1, 3'b001, 6, 8);
      nd = 0;
      repeat (12000) begin
         a = 8'($urandom);
         sel = $urandom_range(0, 3);
         b = (sel == 0) ? a : (sel == 1) ? (a ^ (8'd1 << $urandom_range(0, 7))) : 8'($urandom);
         start = ($urandom_range(0, 3) != 0);
         tick();
         if (done[1]) nd++;
      end
      start = 1'b0;
      repeat (12) tick();
      chk("rand_ee0_compares_ge_1000", int'(nd >= 1000), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
